// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder; optional MMIO register at 32'hFFFF_FFF0 when DMEM_MMIO_EN is defined.
// Latency: accept edge + LATENCY WAIT cycles, then a one-cycle RESP with ready=1 (busy high LATENCY+1 cycles).
// Backpressure: busy (combinational) stalls the pipeline; req must stay stable until busy drops.
module dmem_responder #(
   parameter int ADDR_BITS = 12,
   parameter int LATENCY   = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        wren,
   input  logic [31:0] address,
   input  logic [31:0] dataIn,
   output logic [31:0] dataOut,
   output logic        ready,
   output logic        busy,
   output logic [31:0] mmioOut
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t               state, state_nxt;
   logic [3:0]           cnt, cnt_nxt;
   logic [ADDR_BITS-1:0] idx_q;
   logic [31:0]          wdat_q;
   logic                 wren_q;
   logic                 accept;
   logic                 complete;
   logic                 sel_mmio;
   logic                 mem_we;
   logic [31:0]          rd_dat;
   logic                 unused_addr_hi;

   logic [31:0] mem [0:(1<<ADDR_BITS)-1];

   // Upper address bits only matter for the MMIO decode; plain array accesses wrap.
   assign unused_addr_hi = ^address[31:ADDR_BITS];

   // Next-state, countdown and handshake outputs.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      ready     = 1'b0;
      accept    = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            busy = req;
            if (req) begin
               accept    = 1'b1;
               cnt_nxt   = 4'(LATENCY - 1);
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               complete  = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            // req still belongs to the request just serviced, so it is ignored here.
            ready     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, countdown, latched request and load-data register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         idx_q   <= '0;
         wdat_q  <= '0;
         wren_q  <= 1'b0;
         dataOut <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            idx_q  <= address[ADDR_BITS-1:0];
            wdat_q <= dataIn;
            wren_q <= wren;
         end
         if (complete && !wren_q) begin
            dataOut <= rd_dat;
         end
      end
   end

   // A store commits only at the completion edge; reset forces IDLE so an aborted store never writes.
   assign mem_we = complete & wren_q & ~sel_mmio;

   // Array write port; contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[idx_q] <= wdat_q;
      end
   end

`ifdef DMEM_MMIO_EN
   logic        is_mmio_q;
   logic [31:0] mmio_q;

   // MMIO decode on the full 32-bit address at acceptance; register updated at the completion edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         is_mmio_q <= 1'b0;
         mmio_q    <= '0;
      end else begin
         if (accept) begin
            is_mmio_q <= (address == 32'hFFFF_FFF0);
         end
         if (complete && wren_q && is_mmio_q) begin
            mmio_q <= wdat_q;
         end
      end
   end

   assign sel_mmio = is_mmio_q;
   assign rd_dat   = is_mmio_q ? mmio_q : mem[idx_q];
   assign mmioOut  = mmio_q;
`else
   assign sel_mmio = 1'b0;
   assign rd_dat   = mem[idx_q];
   assign mmioOut  = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_BITS=12, LATENCY=2).
// Each request takes 3 busy cycles then one ready cycle.
// Checks: reset, store/load, wrap, held req, reset aborts, optional MMIO.
module tb_dmem_responder;

   logic        clock;
   logic        reset;
   logic        req;
   logic        wren;
   logic [31:0] address;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic        ready;
   logic        busy;
   logic [31:0] mmioOut;

   int total = 0;
   int bad   = 0;

   dmem_responder #(.ADDR_BITS(12), .LATENCY(2)) dut (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .wren    (wren),
      .address (address),
      .dataIn  (dataIn),
      .dataOut (dataOut),
      .ready   (ready),
      .busy    (busy),
      .mmioOut (mmioOut)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Presents one request from IDLE; counts busy cycles and ready pulses (bounded), returns RESP-cycle data.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int nbusy, output int nrdy, output logic [31:0] rdat);
      req = 1'b1; wren = wr; address = a; dataIn = d;
      nbusy = 0; nrdy = 0; rdat = '0;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (ready) begin
            nrdy++;
            rdat = dataOut;
            req = 1'b0;
            wren = 1'b0;
            break;
         end
         if (busy) nbusy++;
         tick();
      end
      req = 1'b0;
      tick();
      if (ready) nrdy++;
   endtask

   int          nb, nr;
   logic [31:0] rd;
   int          pulses;
   int          pos [3];
   logic [31:0] pdat [3];

   initial begin
      reset = 1'b0; req = 1'b0; wren = 1'b0; address = '0; dataIn = '0;
      #1 reset = 1'b1;
      tick();
      chk("rst_dataOut", dataOut, 32'h0);
      chk("rst_ready", {31'h0, ready}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      tick();

      // Known contents at 0x30, then a store held in reset must not land.
      xfer(1'b1, 32'h30, 32'h1111_1111, nb, nr, rd);
      reset = 1'b1; req = 1'b1; wren = 1'b1; address = 32'h30; dataIn = 32'h5555;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_req_ready", {31'h0, ready}, 32'h0);
      end
      req = 1'b0; wren = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      xfer(1'b0, 32'h30, 32'h0, nb, nr, rd);
      chk("rst_req_noaccess", rd, 32'h1111_1111);

      // Store then load 0x10.
      xfer(1'b1, 32'h10, 32'hDEAD_BEEF, nb, nr, rd);
      chk("st_busy_cycles", nb, 3);
      chk("st_ready_pulses", nr, 1);
      xfer(1'b0, 32'h10, 32'h0, nb, nr, rd);
      chk("ld_busy_cycles", nb, 3);
      chk("ld_ready_pulses", nr, 1);
      chk("ld_data", rd, 32'hDEAD_BEEF);
      chk("ld_hold", dataOut, 32'hDEAD_BEEF);

      // Store leaves dataOut alone; aliased load sees the new word.
      xfer(1'b1, 32'h5, 32'h1234, nb, nr, rd);
      chk("st_keeps_dataOut", dataOut, 32'hDEAD_BEEF);
      xfer(1'b0, 32'h1005, 32'h0, nb, nr, rd);
      chk("wrap_data", rd, 32'h1234);

      // Continuous req for 12 cycles; address moves during the first WAIT.
      xfer(1'b1, 32'h40, 32'hA0A0, nb, nr, rd);
      xfer(1'b1, 32'h41, 32'hB1B1, nb, nr, rd);
      pulses = 0;
      req = 1'b1; wren = 1'b0; address = 32'h40;
      #1;
      for (int k = 0; k < 12; k++) begin
         if (ready) begin
            if (pulses < 3) begin
               pos[pulses]  = k;
               pdat[pulses] = dataOut;
            end
            pulses++;
         end
         if (k == 1) address = 32'h41;
         tick();
      end
      req = 1'b0;
      tick();
      tick();
      chk("held_pulses", pulses, 3);
      if (pulses == 3) begin
         chk("held_first_pos", pos[0], 3);
         chk("held_gap1", pos[1] - pos[0], 4);
         chk("held_gap2", pos[2] - pos[1], 4);
         chk("held_latched_addr", pdat[0], 32'hA0A0);
         chk("held_second_addr", pdat[1], 32'hB1B1);
      end

      // Reset in the second WAIT of a store aborts it.
      xfer(1'b1, 32'h20, 32'h0, nb, nr, rd);
      req = 1'b1; wren = 1'b1; address = 32'h20; dataIn = 32'hAAAA;
      tick();
      tick();
      chk("abort_busy_in_wait", {31'h0, busy}, 32'h1);
      reset = 1'b1; req = 1'b0; wren = 1'b0;
      #1;
      chk("abort_ready", {31'h0, ready}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      tick();
      chk("abort_ready_next", {31'h0, ready}, 32'h0);
      reset = 1'b0;
      tick();
      chk("abort_ready_after", {31'h0, ready}, 32'h0);
      xfer(1'b0, 32'h20, 32'h0, nb, nr, rd);
      chk("abort_not_written", rd, 32'h0);

      // Reset during RESP drops ready at once.
      xfer(1'b0, 32'h10, 32'h0, nb, nr, rd);
      req = 1'b1; wren = 1'b0; address = 32'h10;
      for (int i = 0; i < 20 && !ready; i++) tick();
      chk("resp_reached", {31'h0, ready}, 32'h1);
      req = 1'b0;
      reset = 1'b1;
      #1;
      chk("resp_reset_ready", {31'h0, ready}, 32'h0);
      chk("resp_reset_dataOut", dataOut, 32'h0);
      tick();
      reset = 1'b0;
      tick();

`ifdef DMEM_MMIO_EN
      xfer(1'b1, 32'hFF0, 32'h77, nb, nr, rd);
      chk("mmio_rst", mmioOut, 32'h0);
      xfer(1'b1, 32'hFFFF_FFF0, 32'h00FF, nb, nr, rd);
      chk("mmio_busy_cycles", nb, 3);
      chk("mmio_reg", mmioOut, 32'h00FF);
      xfer(1'b0, 32'hFF0, 32'h0, nb, nr, rd);
      chk("mmio_array_untouched", rd, 32'h77);
      xfer(1'b0, 32'hFFFF_FFF0, 32'h0, nb, nr, rd);
      chk("mmio_load", rd, 32'h00FF);
`else
      xfer(1'b1, 32'hFFFF_FFF0, 32'h99, nb, nr, rd);
      chk("nommio_out", mmioOut, 32'h0);
      xfer(1'b0, 32'hFF0, 32'h0, nb, nr, rd);
      chk("nommio_alias", rd, 32'h99);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the memory-stage dmem interface.
- Accepts word-addressed load/store requests from the pipeline's memory stage and services them with a fixed, parameterised latency.
- Holds the pipeline through a combinational busy (stall) output.
- Returns load data in a registered output that is valid during a one-cycle response window.

Parameters:
ADDR_BITS, 12, word-index width; array depth = 2**ADDR_BITS words of 32 bits
LATENCY, 2, number of WAIT cycles before the access completes; legal range 1..15

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  memory stage presents a load or store; held stable until busy is low
wren  input  1  1 = store, 0 = load; sampled with req
address  input  32  word address; only bits [ADDR_BITS-1:0] are used
dataIn  input  32  store data
dataOut  output  32  load data, registered
ready  output  1  one-cycle pulse marking the response cycle
busy  output  1  stall request to the pipeline (combinational)
mmioOut  output  32  MMIO register value; tied to 0 when the optional feature is off

Behaviour:
- Reset values, asynchronous: state=IDLE, cnt=0, dataOut=0, ready=0, latched request cleared, mmio register=0.
- The memory array is not cleared by reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - busy = req (combinational).
  - On a rising edge with req=1: latch address[ADDR_BITS-1:0], dataIn and wren; set cnt = LATENCY-1; go to WAIT.
  - ready=0.
- WAIT:
  - busy=1.
  - If cnt != 0: decrement cnt.
  - If cnt == 0, at that edge:
    - Store: write the latched data to array[latched index].
    - Load: dataOut <= array[latched index].
    - Go to RESP.
- RESP:
  - busy=0, ready=1 for exactly this cycle.
  - req is ignored; it still belongs to the request just serviced.
  - Go to IDLE unconditionally.
- dataOut:
  - Holds its value until the next completed load.
  - A store does not change dataOut.
- Timing: busy is high for LATENCY+1 consecutive cycles per request. The first response is the cycle after the last busy cycle.
- Input changes: address, dataIn and wren changes after acceptance are ignored; the latched copies are used.
- Back-to-back requests: the earliest next acceptance is the cycle after RESP. A req held high continuously is therefore serviced once per LATENCY+2 cycles.
- Read-after-write: a load to an address stored by the previous request returns the new data, since the write commits before the load is accepted.
- Address wrap: bits above ADDR_BITS are discarded. For ADDR_BITS=12, addresses 0x1005 and 0x0005 alias.
- Reset mid-operation: the pending request is aborted. A store in WAIT is discarded and never written; ready is not pulsed.
- Reset during RESP: ready drops immediately (asynchronous).
- wren is only meaningful while req=1; wren with req=0 has no effect.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - Address 32'hFFFF_FFF0 is decoded on the full 32 bits before truncation and maps to a 32-bit register driven on mmioOut.
  - A store to that address updates the register at the completion edge; the array is not written.
  - A load from that address returns the register value.
  - Latency is unchanged.
- Undefined:
  - No decode; mmioOut is constant 0.
  - 32'hFFFF_FFF0 aliases to array index {ADDR_BITS{...}} of its low bits, like any other address.

Test Plan:
- Reset with req=0 -> dataOut=0, ready=0, busy=0. Assert req with reset high -> state stays IDLE, no access.
- LATENCY=2: store address=0x10, data=0xDEADBEEF, then load 0x10 -> busy high 3 cycles per request; ready pulses once each; dataOut=0xDEADBEEF in the load's RESP cycle.
- Store 0x5 = 0x1234, then load 0x1005 (ADDR_BITS=12) -> dataOut=0x1234 (wrap).
- Hold req=1 for 12 cycles, LATENCY=2, loads -> exactly 3 ready pulses, spaced 4 cycles apart; change address during WAIT -> the originally latched address is read.
- Store 0x20 = 0xAAAA; assert reset during the second WAIT cycle; then load 0x20 -> dataOut is the prior contents (preloaded 0x0), not 0xAAAA; no ready pulse for the aborted store.
- With DMEM_MMIO_EN: store 0xFFFFFFF0 = 0x00FF -> mmioOut=0x00FF after the completion edge; array[0xFF0] unchanged; load 0xFFFFFFF0 -> dataOut=0x00FF.
